// File: rtl/ifu_iccm_dma_arb_if.sv
// ifu_iccm_dma_arb_if: bundles the DMA slave port, the fetch-control handshake and the
// ICCM macro port that the ICCM/DMA arbiter sits between.
//   slave  : the arbiter itself
//   master : the surrounding environment (DMA controller, fetch control, ICCM wrapper)
interface ifu_iccm_dma_arb_if;
  // DMA controller side
  logic        dma_iccm_req;
  logic        dma_iccm_write;
  logic [31:0] dma_iccm_addr;
  logic [63:0] dma_iccm_wdata;
  logic        dma_iccm_gnt;
  logic        dma_iccm_rvalid;
  logic [63:0] dma_iccm_rdata;
  // fetch control side
  logic        ifc_dma_access_ok;
  logic        dma_iccm_stall_any;
  logic        dma_iccm_starve;
  // ICCM macro side
  logic [63:0] iccm_rd_data;
  logic        iccm_dma_rden;
  logic        iccm_dma_wren;
  logic [31:0] iccm_dma_addr;
  logic [63:0] iccm_dma_wdata;

  modport slave (
    input  dma_iccm_req,
    input  dma_iccm_write,
    input  dma_iccm_addr,
    input  dma_iccm_wdata,
    input  ifc_dma_access_ok,
    input  iccm_rd_data,
    output dma_iccm_gnt,
    output iccm_dma_rden,
    output iccm_dma_wren,
    output iccm_dma_addr,
    output iccm_dma_wdata,
    output dma_iccm_rvalid,
    output dma_iccm_rdata,
    output dma_iccm_stall_any,
    output dma_iccm_starve
  );

  modport master (
    output dma_iccm_req,
    output dma_iccm_write,
    output dma_iccm_addr,
    output dma_iccm_wdata,
    output ifc_dma_access_ok,
    output iccm_rd_data,
    input  dma_iccm_gnt,
    input  iccm_dma_rden,
    input  iccm_dma_wren,
    input  iccm_dma_addr,
    input  iccm_dma_wdata,
    input  dma_iccm_rvalid,
    input  dma_iccm_rdata,
    input  dma_iccm_stall_any,
    input  dma_iccm_starve
  );
endinterface

// File: rtl/ifu_iccm_dma_arb.sv
// ifu_iccm_dma_arb: shares the single ICCM array port between instruction fetch and DMA.
// Fetch has priority; DMA only gets the port when fetch control reports it idle. A DMA
// request that waits DMA_MAX_WAIT cycles moves the FSM to STALL, which freezes fetch
// until DMA is served. Reads return with a fixed latency of ICCM_RD_LAT cycles.
// Optional build macro: RV_ICCM_DMA_BURST_EN -- lets STALL serve up to DMA_BURST_MAX
// back-to-back grants before handing the port back to fetch.
module ifu_iccm_dma_arb #(
  parameter int unsigned DMA_MAX_WAIT  = 8,
  parameter int unsigned ICCM_RD_LAT   = 2,
  parameter int unsigned DMA_BURST_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  ifu_iccm_dma_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(DMA_MAX_WAIT - 1);

  state_t                 state_reg, state_next;
  logic [7:0]             wait_cnt_reg, wait_cnt_next;
  logic                   stall_any_reg, starve_reg;
  logic [ICCM_RD_LAT-1:0] rd_pipe_reg;
  logic                   gnt;
  logic                   rd_fire;

`ifdef RV_ICCM_DMA_BURST_EN
  localparam logic [3:0] BURST_LAST = 4'(DMA_BURST_MAX - 1);
  logic [3:0]             burst_cnt_reg, burst_cnt_next;
`endif

  // The low address bits select bytes within the 64-bit word and are dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, bus.dma_iccm_addr[2:0]};

  // State register, wait/burst counters and the registered fetch-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      stall_any_reg <= 1'b0;
      starve_reg    <= 1'b0;
`ifdef RV_ICCM_DMA_BURST_EN
      burst_cnt_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      stall_any_reg <= (state_next == STALL);
      starve_reg    <= (state_reg == REQ) && (state_next == STALL);
`ifdef RV_ICCM_DMA_BURST_EN
      burst_cnt_reg <= burst_cnt_next;
`endif
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
`ifdef RV_ICCM_DMA_BURST_EN
    burst_cnt_next = burst_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        wait_cnt_next = '0;
        if (bus.dma_iccm_req) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (gnt) begin
          // A grant on the limit cycle wins: no STALL, no starve pulse.
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else begin
          if (wait_cnt_reg == WAIT_LIMIT) begin
            state_next = STALL;
`ifdef RV_ICCM_DMA_BURST_EN
            burst_cnt_next = '0;
`endif
          end
          if (wait_cnt_reg != 8'hFF) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
      end
      STALL: begin
`ifdef RV_ICCM_DMA_BURST_EN
        if (gnt) begin
          wait_cnt_next = '0;
          if (burst_cnt_reg < BURST_LAST) begin
            burst_cnt_next = burst_cnt_reg + 4'd1;
          end else begin
            state_next = IDLE;
          end
        end else if (!bus.dma_iccm_req) begin
          // DMA has nothing more queued; give the port back to fetch.
          state_next = IDLE;
        end
`else
        if (gnt) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else if (!bus.dma_iccm_req) begin
          state_next = IDLE;
        end
`endif
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Grant, ICCM strobes and address/data; address and data are zero when not granted.
  always_comb begin
    gnt     = bus.dma_iccm_req & bus.ifc_dma_access_ok &
              ((state_reg == REQ) | (state_reg == STALL));
    rd_fire = gnt & ~bus.dma_iccm_write;
    bus.dma_iccm_gnt  = gnt;
    bus.iccm_dma_rden = rd_fire;
    bus.iccm_dma_wren = gnt & bus.dma_iccm_write;
    bus.iccm_dma_addr = gnt ? {bus.dma_iccm_addr[31:3], 3'b000} : 32'h0;
    bus.iccm_dma_wdata = (gnt & bus.dma_iccm_write) ? bus.dma_iccm_wdata : 64'h0;
    bus.dma_iccm_rvalid = rd_pipe_reg[ICCM_RD_LAT-1];
    bus.dma_iccm_rdata  = rd_pipe_reg[ICCM_RD_LAT-1] ? bus.iccm_rd_data : 64'h0;
    bus.dma_iccm_stall_any = stall_any_reg;
    bus.dma_iccm_starve    = starve_reg;
  end

  // One valid bit per outstanding read so back-to-back reads return in order, gap-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_reg <= '0;
    end else begin
      rd_pipe_reg[0] <= rd_fire;
      for (int i = 1; i < int'(ICCM_RD_LAT); i++) begin
        rd_pipe_reg[i] <= rd_pipe_reg[i-1];
      end
    end
  end

`ifndef SYNTHESIS
  // DMA must hold its request until it is granted.
  req_held_until_gnt : assert property (
    @(posedge clk) disable iff (rst)
    (bus.dma_iccm_req && !gnt) |=> bus.dma_iccm_req
  );
`endif

endmodule
